// File: rtl/seq_detect_ctrl_if.sv
// Word-level handshake between a producer and seq_detect_ctrl.
// Define SEQ_CTRL_ABORT_EN to add the abort request line.
interface seq_detect_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
`ifdef SEQ_CTRL_ABORT_EN
  logic             abort;
`endif
  logic [WIDTH-1:0] data_in;
  logic             ready;
  logic             busy;
  logic [CNT_W-1:0] match_cnt;
  logic             done;

  modport master (
    output start,
`ifdef SEQ_CTRL_ABORT_EN
    output abort,
`endif
    output data_in,
    input  ready, busy, match_cnt, done
  );

  modport slave (
    input  start,
`ifdef SEQ_CTRL_ABORT_EN
    input  abort,
`endif
    input  data_in,
    output ready, busy, match_cnt, done
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Clears a two-in-a-row detector, shifts a word into it MSB-first and counts its hits.
// Optional SEQ_CTRL_ABORT_EN adds an abort that flushes the detector and returns to IDLE.
module seq_detect_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  seq_detect_ctrl_if.slave   bus,
  output logic               det_rst,
  output logic               det_w,
  input  logic               det_out
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
`ifdef SEQ_CTRL_ABORT_EN
    FLUSH,
`endif
    DONE
  } state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] sr;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             abort_hit;
  logic             det_rst_d;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    abort_hit  = 1'b0;
    case (state)
      IDLE:    if (bus.start) next_state = CLEAR;
      CLEAR:   next_state = SHIFT;
      SHIFT:   if (idx == LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
`ifdef SEQ_CTRL_ABORT_EN
    abort_hit = bus.abort && (state == CLEAR || state == SHIFT);
    if (abort_hit) next_state = FLUSH;
    det_rst_d = (next_state == CLEAR) || (next_state == FLUSH);
    bus.busy  = (state == CLEAR) || (state == SHIFT) || (state == FLUSH);
`else
    det_rst_d = (next_state == CLEAR);
    bus.busy  = (state == CLEAR) || (state == SHIFT);
`endif
  end

  // sr is shifted once at the CLEAR edge, so its MSB is always the next bit to present.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr      <= '0;
      idx     <= '0;
      cnt     <= '0;
      det_rst <= 1'b1;
      det_w   <= 1'b0;
    end else begin
      det_rst <= det_rst_d;
      det_w   <= (next_state == SHIFT) ? sr[WIDTH-1] : 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sr  <= bus.data_in;
            cnt <= '0;
            idx <= '0;
          end
        end
        CLEAR: sr <= {sr[WIDTH-2:0], 1'b0};
        SHIFT: begin
          sr  <= {sr[WIDTH-2:0], 1'b0};
          idx <= idx + 1'b1;
          if (det_out) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
      if (abort_hit) cnt <= '0;
    end
  end

  assign bus.ready     = (state == IDLE);
  assign bus.done      = (state == DONE);
  assign bus.match_cnt = cnt;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl with a behavioural two-in-a-row detector and a done scoreboard.
// Build with SEQ_CTRL_ABORT_EN defined to also exercise abort.
module tb_seq_detect_ctrl;
  localparam int W  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  logic det_rst, det_w, det_out;
  logic [1:0] dst;

  seq_detect_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  seq_detect_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .det_rst (det_rst),
    .det_w   (det_w),
    .det_out (det_out)
  );

  always #5 clk = ~clk;

  // Detector: 0 = A (reset), 1 = last bit 0, 2 = last bit 1.
  always @(posedge clk) begin
    if (det_rst) dst <= 2'd0;
    else         dst <= det_w ? 2'd2 : 2'd1;
  end
  assign det_out = (dst == 2'd1 && !det_w) || (dst == 2'd2 && det_w);

  typedef struct { int cnt; int cyc; } exp_t;
  exp_t sb[$];
  int   acc_cyc[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  int   done_seen = 0;
  int   exp_dones = 0;

  function automatic int ref_count(input logic [W-1:0] w);
    int c = 0;
    for (int i = 1; i < W; i++) if (w[i] == w[i-1]) c++;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, bus.ready, 1);
  endtask

  task automatic run_word(input logic [W-1:0] w);
    wait_ready("ready_before_word");
    bus.data_in = w;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    exp_dones++;
    chk("busy_after_accept", bus.busy, 1);
    tick();
    wait_ready("ready_after_word");
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) sb.delete();
    else if (bus.start && bus.ready) begin
      sb.push_back('{ref_count(bus.data_in), cyc + 1 + W + 1});
      acc_cyc.push_back(cyc + 1);
    end
`ifdef SEQ_CTRL_ABORT_EN
    if (!reset && bus.abort && bus.busy) sb.delete();
`endif
  end

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      exp_t e;
      done_seen++;
      if (sb.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        chk("match_cnt_at_done", 32'(bus.match_cnt), e.cnt);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] pat;
    int n;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.data_in = '0;
`ifdef SEQ_CTRL_ABORT_EN
    bus.abort   = 1'b0;
`endif
    tick(); tick(); tick();
    chk("rst_det_rst", det_rst, 1);
    chk("rst_ready", bus.ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_match_cnt", 32'(bus.match_cnt), 0);
    reset = 1'b0;
    tick();
    chk("det_rst_released", det_rst, 0);

    // F0: detailed serial pattern; data_in changes mid-word must be ignored.
    pat = 8'hF0;
    wait_ready("ready_f0");
    bus.data_in = pat;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.data_in = 8'h00;
    exp_dones++;
    chk("clear_det_rst", det_rst, 1);
    chk("clear_det_w", det_w, 0);
    chk("clear_busy", bus.busy, 1);
    chk("clear_ready", bus.ready, 0);
    for (int k = 0; k < W; k++) begin
      tick();
      chk("shift_det_w", det_w, pat[W-1-k]);
      chk("shift_det_rst", det_rst, 0);
    end
    tick();
    chk("done_pulse", bus.done, 1);
    chk("done_ready", bus.ready, 0);
    tick();
    chk("idle_after_done", bus.ready, 1);
    chk("f0_count_held", 32'(bus.match_cnt), 6);

    run_word(8'hAA);
    run_word(8'h00);
    run_word(8'hFF);
    tick(); tick(); tick();
    chk("count_held_idle", 32'(bus.match_cnt), 7);

    // start held high with alternating words.
    bus.data_in = 8'hF0;
    bus.start   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ready("ready_alt");
      tick();
      exp_dones++;
      chk("alt_accepted", bus.busy, 1);
      bus.data_in = (i % 2 == 0) ? 8'hAA : 8'hF0;
    end
    wait_ready("ready_alt_end");
    bus.start = 1'b0;
    n = acc_cyc.size();
    for (int j = n - 3; j < n; j++) chk("alt_period", acc_cyc[j] - acc_cyc[j-1], W + 3);

    // Reset in the 4th SHIFT cycle.
    wait_ready("ready_rst_test");
    bus.data_in = 8'hFF;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    tick(); tick(); tick(); tick();
    chk("mid_shift_busy", bus.busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_ready", bus.ready, 1);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_match_cnt", 32'(bus.match_cnt), 0);
    chk("midrst_det_rst", det_rst, 1);
    tick();
    chk("midrst_det_rst_release", det_rst, 0);
    run_word(8'hFF);

`ifdef SEQ_CTRL_ABORT_EN
    // Abort in the 3rd SHIFT cycle.
    wait_ready("ready_abort_test");
    bus.data_in = 8'hFF;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    tick(); tick(); tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_det_rst", det_rst, 1);
    chk("abort_match_cnt", 32'(bus.match_cnt), 0);
    chk("abort_done", bus.done, 0);
    tick();
    chk("abort_idle", bus.ready, 1);
    chk("abort_det_rst_release", det_rst, 0);
    run_word(8'h0F);
`endif

    tick(); tick(); tick();
    chk("done_pulse_count", done_seen, exp_dones);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
